// File: rtl/mul_pkg.sv
// Shared definitions for the sequential 32x32 multiplier.
//   state_e : controller states (IDLE / RUN / DONE)
//   ITER    : number of shift-and-add iterations per multiply
//   CNT_W   : width of the iteration counter
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int ITER  = 32;
    localparam int CNT_W = 5;

endpackage

// File: rtl/mul32_seq_if.sv
// Start/ready/done handshake bundle between the control unit and the
// sequential multiplier.
//   start   : request, honoured only while ready is high
//   a, b    : multiplicand / multiplier, sampled at acceptance
//   ready   : multiplier idle and able to accept
//   done    : one-cycle pulse when product becomes valid
//   product : 64-bit result, held until the next acceptance
interface mul32_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               ready;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (output start, output a, output b,
                    input  ready, input  done, input  product);

    modport slave  (input  start, input  a, input  b,
                    output ready, output done, output product);
endinterface

// File: rtl/mul32_seq_adc32.sv
// 32-bit carry adder: S = A + B + C0, with carry out Co.
//   a_i, b_i : addends
//   c0_i     : carry in
//   s_o      : 32-bit sum
//   co_o     : carry out
module mul32_seq_adc32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        c0_i,
    output logic [31:0] s_o,
    output logic        co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, c0_i};

endmodule

// File: rtl/mul32_seq.sv
// Multi-cycle 32x32->64 unsigned shift-and-add multiplier. A single 32-bit
// adder is reused for 32 iterations; each iteration conditionally adds the
// multiplicand into the upper half of the partial product and shifts the
// whole {p_hi, p_lo} pair right by one, consuming one multiplier bit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards any operation in flight
//   bus   : start/a/b in, ready/done/product out (slave side)
module mul32_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    mul32_seq_if.slave  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   m_q,     m_d;
    logic [WIDTH-1:0]   p_hi_q,  p_hi_d;
    logic [WIDTH-1:0]   p_lo_q,  p_lo_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_s;
    logic               add_co;

    // The current multiplier bit selects whether the multiplicand is added.
    assign add_b = p_lo_q[0] ? m_q : '0;

    mul32_seq_adc32 u_adc32 (
        .a_i  (p_hi_q),
        .b_i  (add_b),
        .c0_i (1'b0),
        .s_o  (add_s),
        .co_o (add_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.a;
                    p_hi_d  = '0;
                    p_lo_d  = bus.b;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // {p_hi, p_lo} <= {Co, S, p_lo[31:1]}: the carry lands in bit
                // 31 of p_hi and the sum's LSB shifts into the top of p_lo.
                p_hi_d = {add_co, add_s[WIDTH-1:1]};
                p_lo_d = {add_s[0], p_lo_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign bus.ready   = (state_q == IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.product = {p_hi_q, p_lo_q};

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: table-driven vectors plus hand-written
// sequences for back-to-back starts, mid-operation reset and idle hold.
// A scoreboard records every accepted request and checks it against the
// next done pulse, including the 32-cycle acceptance-to-done latency.
module tb_mul32_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mul32_seq_if #(.WIDTH(32)) bus ();

    mul32_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: condition not met", nm);
    endtask

    // ---------------- scoreboard ----------------
    int unsigned    cyc = 0;
    logic [63:0]    exp_q[$];
    int unsigned    acc_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.start && bus.ready) begin
            exp_q.push_back({32'b0, bus.a} * {32'b0, bus.b});
            acc_q.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                fail_now("sb unexpected done");
            end else begin
                logic [63:0] e;
                int unsigned k;
                e = exp_q.pop_front();
                k = acc_q.pop_front();
                chk("sb product", bus.product, e);
                chk("sb latency", 64'(cyc - k - 1), 64'd32);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now({nm, " done timeout"});
    endtask

    task automatic run_op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] pexp);
        bit ok;
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, " ready low"}, 64'(bus.ready), 64'd0);
        wait_done(nm, ok);
        if (ok) begin
            chk({nm, " product"}, bus.product, pexp);
            @(negedge clk);
            chk({nm, " ready back"}, 64'(bus.ready), 64'd1);
            chk({nm, " done low"}, 64'(bus.done), 64'd0);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [63:0] held;

        vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h0,         32'h1234_5678, 64'h0};
        vecs[3] = '{32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};
        vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080};
        vecs[5] = '{32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF};

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst ready", 64'(bus.ready), 64'd1);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst product", bus.product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // table vectors
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // start held high with changing operands through RUN
        bus.a = 32'd3;
        bus.b = 32'd5;
        bus.start = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            bus.a = $urandom;
            bus.b = $urandom;
        end
        if (!ok) fail_now("b2b first done timeout");
        chk("b2b first product", bus.product, 64'h0000_0000_0000_000F);
        bus.a = 32'd11;
        bus.b = 32'd13;
        @(negedge clk);
        chk("b2b ready edge", 64'(bus.ready), 64'd1);
        chk("b2b prev product kept", bus.product, 64'h0000_0000_0000_000F);
        @(negedge clk);
        chk("b2b accepted", 64'(bus.ready), 64'd0);
        bus.start = 1'b0;
        bus.a = 32'hA5A5_A5A5;
        bus.b = 32'h5A5A_5A5A;
        wait_done("b2b second", ok);
        if (ok) chk("b2b second product", bus.product, 64'd143);
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h0000_1234;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst ready", 64'(bus.ready), 64'd1);
        chk("arst done", 64'(bus.done), 64'd0);
        chk("arst product", bus.product, 64'd0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after rst", 32'd7, 32'd6, 64'd42);

        // idle hold: inputs toggle with start low
        held = bus.product;
        chk("hold start value", held, 64'd42);
        for (int i = 0; i < 20; i++) begin
            bus.a = $urandom;
            bus.b = $urandom;
            bus.start = 1'b0;
            @(negedge clk);
            chk("hold product", bus.product, held);
            chk("hold ready", 64'(bus.ready), 64'd1);
            chk("hold done", 64'(bus.done), 64'd0);
        end

        chk("sb drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
